motor_pwm_generator: RTL and testbench
======================================

Name: motor_pwm_generator

Overview:
- Converts the four 8-bit motor rates from the motor mixer into four ESC-style servo PWM waveforms.
- Pulse width ranges from about 1 ms (rate 0) to about 2 ms (rate 255), in a frame of about 20 ms.
- Sits between the motor mixer and the FPGA pins driving the ESCs.
- Includes a power-up arming interval and a frame-synchronous enable (kill switch), so no pulse is ever truncated or glitched.

Parameters:
- STEP_CLKS, 148: sys_clk cycles per PWM step (38 MHz / 148 ≈ 3.9 µs; 256 steps ≈ 1 ms).
- MIN_STEPS, 256: fixed pulse steps added to every rate (rate 0 → 1 ms).
- FRAME_STEPS, 5120: steps per PWM frame (≈ 20 ms, 50 Hz).
- ARM_FRAMES, 100: frames of forced minimum pulse after reset (≈ 2 s).

Ports:
- sys_clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-high (1 = reset); name retained per codebase.
- enable  in  1  1 = pass motor rates; 0 = force minimum pulse.
- motor_1_rate  in  8  unsigned rate from mixer (same for motor_2_rate, motor_3_rate, motor_4_rate).
- motor_1_pwm  out  1  ESC pulse (same for motor_2_pwm, motor_3_pwm, motor_4_pwm).
- frame_start  out  1  one-cycle strobe at the start of each frame.
- armed  out  1  1 once the arming interval is complete.

Behaviour:
- Reset (resetn=1 sampled at a sys_clk edge):
  - Outputs: all motor_x_pwm=0, frame_start=0, armed=0.
  - Internal: step_cnt=0, frame_cnt=0, arm_cnt=0, latched rates=0, state=ARMING.
  - Reset asserted mid-pulse drops all pwm low on that edge; there is no completion of the current frame.
- Counters:
  - step_cnt counts 0..STEP_CLKS-1; step_tick = (step_cnt==STEP_CLKS-1).
  - frame_cnt advances on step_tick and wraps from FRAME_STEPS-1 to 0.
  - frame_boundary = step_tick && frame_cnt==FRAME_STEPS-1.
- Outputs are registered from counter state, giving 1-cycle latency:
  - frame_start=1 in the cycle after counter state (frame_cnt=0, step_cnt=0).
  - motor_x_pwm=1 while the counter state satisfies frame_cnt < MIN_STEPS + latched_x.
  - The pwm rising edge coincides with frame_start.
  - The first frame_start occurs 1 cycle after reset release.
- Pulse width is exactly (MIN_STEPS + latched_x) * STEP_CLKS cycles. Comparison is 13-bit unsigned; the maximum 511 < FRAME_STEPS, so the pulse always ends in-frame.
- Rate latching happens only at frame_boundary, for the next frame. Changes in motor_x_rate mid-frame have no effect on the current pulse.
- Latched value at frame_boundary: latched_x = (state==RUN && enable) ? motor_x_rate : 0.
- enable falling or rising mid-frame takes effect from the next frame only.
- State machine:
  - ARMING: latched rates are forced to 0. At each frame_boundary, arm_cnt increments. When arm_cnt reaches ARM_FRAMES-1 at a frame_boundary, go to RUN and set armed=1 on that same edge. The first RUN frame then latches real rates.
  - RUN: stays in RUN until reset. armed stays 1.
  - Illegal state: behave as ARMING with arm_cnt=0 and armed=0.
- Simultaneous reset and frame_boundary: reset wins.

Decomposition:
- common_defines.v:
  - `MOTOR_RATE_BIT_WIDTH (8), shared with the mixer.
  - `PWM_STEP_CLKS, `PWM_MIN_STEPS, `PWM_FRAME_STEPS, `PWM_ARM_FRAMES as parameter defaults.
- Sub-module pwm_channel, instantiated 4×: rate latch plus compare register. Inputs: sys_clk, resetn, load, load_val, frame_cnt. Output: pwm.
- The top level owns the counters, the state machine, frame_start and armed.

Test Plan:
All scenarios use simulation parameters STEP_CLKS=4, FRAME_STEPS=600, ARM_FRAMES=2 (frame = 2400 cycles).
1. Reset, rates=200, enable=1 → frames 1–2 pulse 1024 cycles on all channels with armed=0. armed=1 at the end of frame 2. Frame 3 pulse is 456*4=1824 cycles.
2. RUN with rates 0/128/255/1 → pulses 1024/1536/2044/1028 cycles. frame_start period is exactly 2400 cycles.
3. Change motor_1_rate 0→255 at cycle 500 of a frame → the current pulse stays 1024; the next frame pulse is 2044. No glitch on motor_1_pwm.
4. enable 1→0 at cycle 100 of a 255-rate frame → the current pulse completes at 2044; the following frames pulse 1024. Re-enable restores 2044 from the next frame.
5. resetn=1 asserted at cycle 700 (mid-pulse) → all pwm=0 and armed=0 on that edge. After release, frame_start follows 1 cycle later, then 2 arming frames.
6. Long run of 10 frames at rate 255 → pwm high exactly 2044 cycles per frame and low 356 cycles, with no drift.

Source files
------------

// File: rtl/motor_pwm_generator_pkg.sv
// Shared widths, parameter defaults and FSM encoding for the ESC PWM generator.
package motor_pwm_generator_pkg;
   localparam int RATE_W     = 8;
   localparam int FRAME_W    = 13;
   localparam int NUM_MOTORS = 4;

   localparam int DEF_STEP_CLKS   = 148;
   localparam int DEF_MIN_STEPS   = 256;
   localparam int DEF_FRAME_STEPS = 5120;
   localparam int DEF_ARM_FRAMES  = 100;

   typedef enum logic [1:0] {
      ST_ARMING = 2'd0,
      ST_RUN    = 2'd1
   } pwm_state_e;
endpackage

// File: rtl/motor_pwm_generator_pwm_channel.sv
// One ESC channel: rate latched once per frame, pulse held high while the
// frame step count is below MIN_STEPS + latched rate.
module motor_pwm_generator_pwm_channel
   import motor_pwm_generator_pkg::*;
#(
   parameter int MIN_STEPS = DEF_MIN_STEPS
) (
   input  logic               sys_clk,
   input  logic               resetn,
   input  logic               load,
   input  logic [RATE_W-1:0]  load_val,
   input  logic [FRAME_W-1:0] frame_cnt,
   output logic               pwm
);
   logic [RATE_W-1:0]  latched;
   logic [FRAME_W-1:0] limit;

   assign limit = FRAME_W'(MIN_STEPS) + FRAME_W'(latched);

   always_ff @(posedge sys_clk) begin
      if (resetn) begin
         latched <= '0;
         pwm     <= 1'b0;
      end else begin
         if (load) latched <= load_val;
         pwm <= (frame_cnt < limit);
      end
   end
endmodule

// File: rtl/motor_pwm_generator.sv
// Four-channel servo/ESC PWM generator with power-up arming and a
// frame-synchronous enable so pulses are never truncated.
module motor_pwm_generator
   import motor_pwm_generator_pkg::*;
#(
   parameter int STEP_CLKS   = DEF_STEP_CLKS,
   parameter int MIN_STEPS   = DEF_MIN_STEPS,
   parameter int FRAME_STEPS = DEF_FRAME_STEPS,
   parameter int ARM_FRAMES  = DEF_ARM_FRAMES
) (
   input  logic              sys_clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic [RATE_W-1:0] motor_1_rate,
   input  logic [RATE_W-1:0] motor_2_rate,
   input  logic [RATE_W-1:0] motor_3_rate,
   input  logic [RATE_W-1:0] motor_4_rate,
   output logic              motor_1_pwm,
   output logic              motor_2_pwm,
   output logic              motor_3_pwm,
   output logic              motor_4_pwm,
   output logic              frame_start,
   output logic              armed
);
   localparam int STEP_W = $clog2(STEP_CLKS + 1);
   localparam int ARM_W  = $clog2(ARM_FRAMES + 1);

   logic [STEP_W-1:0]  step_cnt;
   logic [FRAME_W-1:0] frame_cnt;
   logic [ARM_W-1:0]   arm_cnt;
   pwm_state_e         state, state_nxt;
   logic               step_tick, frame_boundary, arm_done, pass_rates;
   logic [NUM_MOTORS-1:0][RATE_W-1:0] rates, load_vals;
   logic [NUM_MOTORS-1:0]             pwm;

   assign step_tick      = (step_cnt == STEP_W'(STEP_CLKS - 1));
   assign frame_boundary = step_tick && (frame_cnt == FRAME_W'(FRAME_STEPS - 1));
   assign arm_done       = (arm_cnt == ARM_W'(ARM_FRAMES - 1));

   always_ff @(posedge sys_clk) begin
      if (resetn) begin
         step_cnt    <= '0;
         frame_cnt   <= '0;
         frame_start <= 1'b0;
      end else begin
         step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
         if (step_tick) frame_cnt <= frame_boundary ? '0 : frame_cnt + FRAME_W'(1);
         frame_start <= (frame_cnt == '0) && (step_cnt == '0);
      end
   end

   // State register; arm_cnt only moves at frame boundaries while arming.
   always_ff @(posedge sys_clk) begin
      if (resetn) begin
         state   <= ST_ARMING;
         arm_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_ARMING: if (frame_boundary && !arm_done) arm_cnt <= arm_cnt + ARM_W'(1);
            ST_RUN:    arm_cnt <= arm_cnt;
            default:   arm_cnt <= '0;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARMING: if (frame_boundary && arm_done) state_nxt = ST_RUN;
         ST_RUN:    state_nxt = ST_RUN;
         default:   state_nxt = ST_ARMING;
      endcase
   end

   // Rates latched on the arming->run edge already belong to the first RUN frame.
   always_comb begin
      armed      = (state == ST_RUN);
      pass_rates = (state_nxt == ST_RUN) && enable;
   end

   assign rates = {motor_4_rate, motor_3_rate, motor_2_rate, motor_1_rate};

   for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
      assign load_vals[g] = pass_rates ? rates[g] : '0;
      motor_pwm_generator_pwm_channel #(.MIN_STEPS(MIN_STEPS)) u_ch (
         .sys_clk   (sys_clk),
         .resetn    (resetn),
         .load      (frame_boundary),
         .load_val  (load_vals[g]),
         .frame_cnt (frame_cnt),
         .pwm       (pwm[g])
      );
   end

   assign motor_1_pwm = pwm[0];
   assign motor_2_pwm = pwm[1];
   assign motor_3_pwm = pwm[2];
   assign motor_4_pwm = pwm[3];
endmodule

// File: tb/tb_motor_pwm_generator.sv
// Directed bench for motor_pwm_generator using short simulation frames.
module tb_motor_pwm_generator;
   localparam int STEP       = 4;
   localparam int MINS       = 256;
   localparam int FRAME      = 600;
   localparam int ARMF       = 2;
   localparam int FRAME_CLKS = STEP * FRAME;

   logic       sys_clk = 1'b0;
   logic       resetn  = 1'b1;
   logic       enable  = 1'b1;
   logic [7:0] r1 = 8'd200, r2 = 8'd200, r3 = 8'd200, r4 = 8'd200;
   logic       p1, p2, p3, p4, frame_start, armed;
   logic [3:0] pwm_v;

   int tests = 0;
   int fails = 0;

   int   m_hi [4];
   int   m_first_low [4];
   int   m_fs_cnt;
   logic m_armed0;
   int         chg_at = -1;
   logic [7:0] chg_r1 = 8'd0;
   logic       chg_en = 1'b1;
   bit         chg_r1_v = 1'b0, chg_en_v = 1'b0;
   int         exp_w [4];

   assign pwm_v = {p4, p3, p2, p1};

   always #5 sys_clk = ~sys_clk;

   motor_pwm_generator #(
      .STEP_CLKS(STEP), .MIN_STEPS(MINS), .FRAME_STEPS(FRAME), .ARM_FRAMES(ARMF)
   ) dut (
      .sys_clk(sys_clk), .resetn(resetn), .enable(enable),
      .motor_1_rate(r1), .motor_2_rate(r2), .motor_3_rate(r3), .motor_4_rate(r4),
      .motor_1_pwm(p1), .motor_2_pwm(p2), .motor_3_pwm(p3), .motor_4_pwm(p4),
      .frame_start(frame_start), .armed(armed)
   );

   task automatic wait_frame(input string tag);
      int n = 0;
      while (frame_start !== 1'b1 && n < 3 * FRAME_CLKS) begin
         @(negedge sys_clk);
         n++;
      end
      if (frame_start !== 1'b1) begin
         tests++; fails++;
         $display("FAIL %s: frame_start not seen within %0d cycles", tag, 3 * FRAME_CLKS);
      end
   endtask

   // Observes one whole frame starting at a frame_start cycle; applies any pending mid-frame change.
   task automatic measure(input string tag);
      wait_frame(tag);
      m_fs_cnt = 0;
      m_armed0 = armed;
      for (int k = 0; k < 4; k++) begin m_hi[k] = 0; m_first_low[k] = -1; end
      for (int i = 0; i < FRAME_CLKS; i++) begin
         if (i == chg_at) begin
            if (chg_r1_v) r1 = chg_r1;
            if (chg_en_v) enable = chg_en;
         end
         if (frame_start === 1'b1) m_fs_cnt++;
         for (int k = 0; k < 4; k++) begin
            if (pwm_v[k] === 1'b1) m_hi[k]++;
            else if (m_first_low[k] < 0) m_first_low[k] = i;
         end
         @(negedge sys_clk);
      end
      chg_at = -1; chg_r1_v = 1'b0; chg_en_v = 1'b0;
   endtask

   task automatic test_reset();
      tests++;
      if (pwm_v !== 4'h0) begin fails++; $display("FAIL reset_pwm: got %b, expected 0000", pwm_v); end
      tests++;
      if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b, expected 0", frame_start); end
      tests++;
      if (armed !== 1'b0) begin fails++; $display("FAIL reset_armed: got %b, expected 0", armed); end
      resetn = 1'b0;
      @(negedge sys_clk);
      tests++;
      if (frame_start !== 1'b1) begin fails++; $display("FAIL first_frame_start: got %b, expected 1", frame_start); end
   endtask

   task automatic test_arming();
      for (int f = 1; f <= 3; f++) begin
         measure($sformatf("arm_f%0d", f));
         for (int k = 0; k < 4; k++) begin
            exp_w[k] = (f < 3) ? MINS * STEP : (MINS + 200) * STEP;
            tests++;
            if (m_hi[k] !== exp_w[k] || m_first_low[k] !== exp_w[k]) begin
               fails++;
               $display("FAIL arm_f%0d ch%0d: high=%0d first_low=%0d, expected %0d", f, k + 1, m_hi[k], m_first_low[k], exp_w[k]);
            end
         end
         tests++;
         if (m_armed0 !== (f == 3)) begin fails++; $display("FAIL arm_f%0d armed: got %b, expected %0d", f, m_armed0, f == 3); end
      end
   endtask

   task automatic test_rates();
      r1 = 8'd0; r2 = 8'd128; r3 = 8'd255; r4 = 8'd1;
      measure("rates_prev");
      measure("rates");
      exp_w = '{1024, 1536, 2044, 1028};
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (m_hi[k] !== exp_w[k] || m_first_low[k] !== exp_w[k]) begin
            fails++;
            $display("FAIL rates ch%0d: high=%0d first_low=%0d, expected %0d", k + 1, m_hi[k], m_first_low[k], exp_w[k]);
         end
      end
      tests++;
      if (m_fs_cnt !== 1 || frame_start !== 1'b1) begin
         fails++;
         $display("FAIL frame_period: strobes=%0d next_start=%b, expected 1 and 1", m_fs_cnt, frame_start);
      end
   endtask

   task automatic test_mid_frame_rate();
      chg_at = 500; chg_r1 = 8'd255; chg_r1_v = 1'b1;
      measure("midrate_cur");
      tests++;
      if (m_hi[0] !== 1024 || m_first_low[0] !== 1024) begin
         fails++; $display("FAIL midrate_cur: high=%0d first_low=%0d, expected 1024", m_hi[0], m_first_low[0]);
      end
      measure("midrate_next");
      tests++;
      if (m_hi[0] !== 2044 || m_first_low[0] !== 2044) begin
         fails++; $display("FAIL midrate_next: high=%0d first_low=%0d, expected 2044", m_hi[0], m_first_low[0]);
      end
   endtask

   task automatic test_enable();
      r1 = 8'd255; r2 = 8'd255; r3 = 8'd255; r4 = 8'd255;
      measure("en_prev");
      chg_at = 100; chg_en = 1'b0; chg_en_v = 1'b1;
      for (int f = 0; f < 4; f++) begin
         if (f == 2) enable = 1'b1;
         measure($sformatf("en_f%0d", f));
         for (int k = 0; k < 4; k++) begin
            exp_w[k] = (f == 0 || f == 3) ? 2044 : 1024;
            tests++;
            if (m_hi[k] !== exp_w[k] || m_first_low[k] !== exp_w[k]) begin
               fails++;
               $display("FAIL en_f%0d ch%0d: high=%0d first_low=%0d, expected %0d", f, k + 1, m_hi[k], m_first_low[k], exp_w[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      wait_frame("rst_sync");
      repeat (700) @(negedge sys_clk);
      tests++;
      if (pwm_v !== 4'hF || armed !== 1'b1) begin
         fails++; $display("FAIL pre_reset: pwm=%b armed=%b, expected 1111 1", pwm_v, armed);
      end
      resetn = 1'b1;
      @(negedge sys_clk);
      tests++;
      if (pwm_v !== 4'h0 || armed !== 1'b0 || frame_start !== 1'b0) begin
         fails++; $display("FAIL mid_reset: pwm=%b armed=%b fs=%b, expected 0000 0 0", pwm_v, armed, frame_start);
      end
      resetn = 1'b0;
      @(negedge sys_clk);
      tests++;
      if (frame_start !== 1'b1) begin fails++; $display("FAIL post_reset_start: got %b, expected 1", frame_start); end
      for (int f = 1; f <= 2; f++) begin
         measure($sformatf("rearm_f%0d", f));
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (m_hi[k] !== 1024 || m_first_low[k] !== 1024 || m_armed0 !== 1'b0) begin
               fails++;
               $display("FAIL rearm_f%0d ch%0d: high=%0d first_low=%0d armed=%b, expected 1024 1024 0", f, k + 1, m_hi[k], m_first_low[k], m_armed0);
            end
         end
      end
      tests++;
      if (armed !== 1'b1) begin fails++; $display("FAIL rearm_done: armed=%b, expected 1", armed); end
   endtask

   task automatic test_long_run();
      for (int f = 0; f < 10; f++) begin
         measure($sformatf("long_f%0d", f));
         for (int k = 0; k < 4; k++) begin
            tests++;
            if (m_hi[k] !== 2044 || m_first_low[k] !== 2044) begin
               fails++;
               $display("FAIL long_f%0d ch%0d: high=%0d low=%0d first_low=%0d, expected 2044 356", f, k + 1, m_hi[k], FRAME_CLKS - m_hi[k], m_first_low[k]);
            end
         end
         tests++;
         if (m_fs_cnt !== 1) begin fails++; $display("FAIL long_f%0d strobes: got %0d, expected 1", f, m_fs_cnt); end
      end
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      test_reset();
      test_arming();
      test_rates();
      test_mid_frame_rate();
      test_enable();
      test_reset_mid_pulse();
      test_long_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
